dmx2_64bit_pipe: RTL and testbench

DMX2_64BIT_PIPE -- requirements
Module: dmx2_64bit_pipe

---
 rtl/dmx2_64bit_pipe.sv | 91 +++++++++
 tb/tb_dmx2_64bit_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmx2_64bit_pipe.sv
// Two-way 64-bit demultiplexer with a one-entry holding register per channel.
// Optional per-channel output-transfer counters are built when DMX_CNT_EN is defined.
module dmx2_64bit_pipe #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       d,
  input  logic              s,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [63:0]       y0,
  output logic [63:0]       y1,
  output logic              y0_valid,
  output logic              y1_valid,
  input  logic              y0_ready,
`ifdef DMX_CNT_EN
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
`endif
  input  logic              y1_ready
);

  logic [63:0] data0_q, data0_d;
  logic [63:0] data1_q, data1_d;
  logic        full0_q, full0_d;
  logic        full1_q, full1_d;
  logic        in_xfer, load0, load1, out0, out1;

  // A full channel still accepts when its consumer drains it in the same cycle.
  always_comb begin
    ready_out = s ? (~full1_q | y1_ready) : (~full0_q | y0_ready);
    in_xfer   = valid_in & ready_out;
    load0     = in_xfer & ~s;
    load1     = in_xfer & s;
    out0      = full0_q & y0_ready;
    out1      = full1_q & y1_ready;
    full0_d   = load0 | (full0_q & ~y0_ready);
    full1_d   = load1 | (full1_q & ~y1_ready);
    data0_d   = load0 ? d : data0_q;
    data1_d   = load1 ? d : data1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data0_q <= '0;
      data1_q <= '0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      full0_q <= full0_d;
      full1_q <= full1_d;
    end
  end

  assign y0       = data0_q;
  assign y1       = data1_q;
  assign y0_valid = full0_q;
  assign y1_valid = full1_q;

`ifdef DMX_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = out0 ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = out1 ? cnt1_q + CNT_W'(1) : cnt1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_out;
  assign unused_out = out0 ^ out1;
`endif

endmodule

// File: tb/tb_dmx2_64bit_pipe.sv
// Bench for dmx2_64bit_pipe: vector table, directed corner sequences and
// randomized traffic against a queue-based channel model.
module tb_dmx2_64bit_pipe;

  localparam int CNT_W = 8;

  logic        clk;
  logic        reset_n;
  logic [63:0] d;
  logic        s;
  logic        valid_in;
  logic        ready_out;
  logic [63:0] y0, y1;
  logic        y0_valid, y1_valid;
  logic        y0_ready, y1_ready;
`ifdef DMX_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1;
`endif

  dmx2_64bit_pipe #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d        (d),
    .s        (s),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .y0       (y0),
    .y1       (y1),
    .y0_valid (y0_valid),
    .y1_valid (y1_valid),
    .y0_ready (y0_ready),
`ifdef DMX_CNT_EN
    .cnt0     (cnt0),
    .cnt1     (cnt1),
`endif
    .y1_ready (y1_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel is a queue holding at most one word.
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];
  int          mc0 = 0;
  int          mc1 = 0;
  logic        rdy_seen;
  logic        rdy_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    mc0 = 0;
    mc1 = 0;
  endtask

  function automatic logic model_ready(input logic sel, input logic r0, input logic r1);
    if (sel) return (mq1.size() == 0) || r1;
    return (mq0.size() == 0) || r0;
  endfunction

  task automatic model_step(input logic [63:0] dd, input logic sel, input logic v,
                            input logic r0, input logic r1);
    logic rdy;
    rdy = model_ready(sel, r0, r1);
    if (mq0.size() != 0 && r0) begin
      void'(mq0.pop_front());
      mc0 = (mc0 + 1) % (1 << CNT_W);
    end
    if (mq1.size() != 0 && r1) begin
      void'(mq1.pop_front());
      mc1 = (mc1 + 1) % (1 << CNT_W);
    end
    if (v && rdy) begin
      if (sel) mq1.push_back(dd);
      else     mq0.push_back(dd);
    end
  endtask

  // One clock cycle: drive after the falling edge, sample ready before the
  // rising edge, and leave outputs settled 1ns after it.
  task automatic apply(input logic [63:0] dd, input logic sel, input logic v,
                       input logic r0, input logic r1);
    @(negedge clk);
    d = dd; s = sel; valid_in = v; y0_ready = r0; y1_ready = r1;
    #1;
    rdy_seen  = ready_out;
    rdy_model = model_ready(sel, r0, r1);
    @(posedge clk);
    model_step(dd, sel, v, r0, r1);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_v0"}, 64'(y0_valid), 64'(mq0.size() != 0));
    chk({tag, "_v1"}, 64'(y1_valid), 64'(mq1.size() != 0));
    if (mq0.size() != 0) chk({tag, "_y0"}, y0, mq0[0]);
    if (mq1.size() != 0) chk({tag, "_y1"}, y1, mq1[0]);
`ifdef DMX_CNT_EN
    chk({tag, "_cnt0"}, 64'(cnt0), 64'(mc0));
    chk({tag, "_cnt1"}, 64'(cnt1), 64'(mc1));
`endif
  endtask

  typedef struct {
    logic [63:0] d;
    logic        s, v, r0, r1;
    logic        e_rdy, e_v0, e_v1;
    logic [63:0] e_y0, e_y1;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [63:0] dd, input logic sel, input logic v,
                              input logic r0, input logic r1, input logic e_rdy,
                              input logic e_v0, input logic e_v1,
                              input logic [63:0] e_y0, input logic [63:0] e_y1);
    vec_t t;
    t.d = dd; t.s = sel; t.v = v; t.r0 = r0; t.r1 = r1;
    t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_v1 = e_v1; t.e_y0 = e_y0; t.e_y1 = e_y1;
    return t;
  endfunction

  initial begin
    logic [63:0] w;
    logic        rs, rv, rr0, rr1;

    //            d                       s  v  r0 r1 rdy v0 v1 y0      y1
    vecs[0] = mk(64'h0123_4567_89AB_CDEF, 1, 1, 0, 1, 1,  0, 1, 64'h0,  64'h0123_4567_89AB_CDEF);
    vecs[1] = mk(64'h1,                   0, 1, 0, 1, 1,  1, 0, 64'h1,  64'h0);
    vecs[2] = mk(64'h2,                   0, 1, 0, 0, 0,  1, 0, 64'h1,  64'h0);
    vecs[3] = mk(64'hFF,                  1, 1, 0, 0, 1,  1, 1, 64'h1,  64'hFF);
    vecs[4] = mk(64'h2,                   0, 1, 1, 0, 1,  1, 1, 64'h2,  64'hFF);
    vecs[5] = mk(64'h3,                   1, 1, 1, 0, 0,  0, 1, 64'h0,  64'hFF);
    vecs[6] = mk(64'h4,                   1, 0, 0, 1, 1,  0, 0, 64'h0,  64'h0);
    vecs[7] = mk(64'h5,                   0, 0, 0, 0, 1,  0, 0, 64'h0,  64'h0);
    vecs[8] = mk(64'hAA,                  0, 1, 0, 0, 1,  1, 0, 64'hAA, 64'h0);
    vecs[9] = mk(64'hBB,                  1, 1, 1, 0, 1,  0, 1, 64'h0,  64'hBB);

    reset_n = 1'b0; d = '0; s = 1'b0; valid_in = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_v0", 64'(y0_valid), 64'h0);
    chk("rst_v1", 64'(y1_valid), 64'h0);
    chk("rst_y0", y0, 64'h0);
    chk("rst_y1", y1, 64'h0);
`ifdef DMX_CNT_EN
    chk("rst_cnt0", 64'(cnt0), 64'h0);
    chk("rst_cnt1", 64'(cnt1), 64'h0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].d, vecs[i].s, vecs[i].v, vecs[i].r0, vecs[i].r1);
      chk($sformatf("tbl%0d_ready", i), 64'(rdy_seen), 64'(vecs[i].e_rdy));
      chk($sformatf("tbl%0d_v0", i), 64'(y0_valid), 64'(vecs[i].e_v0));
      chk($sformatf("tbl%0d_v1", i), 64'(y1_valid), 64'(vecs[i].e_v1));
      if (vecs[i].e_v0) chk($sformatf("tbl%0d_y0", i), y0, vecs[i].e_y0);
      if (vecs[i].e_v1) chk($sformatf("tbl%0d_y1", i), y1, vecs[i].e_y1);
    end

    // Streaming: one word per cycle on channel 0, each visible the cycle after.
    for (int i = 0; i < 10; i++) begin
      w = 64'h5000_0000_0000_1000 + 64'(i);
      apply(w, 1'b0, 1'b1, 1'b1, 1'b1);
      chk($sformatf("stream%0d_ready", i), 64'(rdy_seen), 64'h1);
      chk($sformatf("stream%0d_v0", i), 64'(y0_valid), 64'h1);
      chk($sformatf("stream%0d_y0", i), y0, w);
    end
    apply(64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_model("drain");

    // Reset between edges while both channels are full.
    apply(64'hA1A1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(64'hB2B2, 1'b1, 1'b1, 1'b0, 1'b0);
    check_model("prerst");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_v0", 64'(y0_valid), 64'h0);
    chk("midrst_v1", 64'(y1_valid), 64'h0);
    chk("midrst_y0", y0, 64'h0);
    chk("midrst_y1", y1, 64'h0);
    model_clear();
    #1 reset_n = 1'b1;
    d = 64'h77; s = 1'b0; valid_in = 1'b1; y0_ready = 1'b0; y1_ready = 1'b0;
    @(posedge clk);
    model_step(64'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("postrst_v0", 64'(y0_valid), 64'h1);
    chk("postrst_y0", y0, 64'h77);
    check_model("postrst");

`ifdef DMX_CNT_EN
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 257; i++) apply(64'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    apply(64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cnt_257_cnt1", 64'(cnt1), 64'h1);
    chk("cnt_257_cnt0", 64'(cnt0), 64'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      w   = {$urandom, $urandom};
      rs  = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) != 0);
      rr0 = ($urandom_range(0, 2) != 0);
      rr1 = ($urandom_range(0, 2) != 0);
      apply(w, rs, rv, rr0, rr1);
      chk($sformatf("rnd%0d_ready", i), 64'(rdy_seen), 64'(rdy_model));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
